// File: rtl/alu_control_unit_if.sv
// Bundle between the sequencer and the program ROM / ALU datapath.
// The master side is the sequencer; the slave side is ROM plus datapath.
interface alu_control_unit_if #(parameter int PC_W = 8);
    logic [7:0]      inst_data;
    logic            alu_cout;
    logic            alu_zout;
    logic [PC_W-1:0] pc;
    logic [1:0]      alu_sel;
    logic [1:0]      load_shift;
    logic            a_src;
    logic [3:0]      reg_addr;
    logic            acc_we;
    logic            reg_we;
    logic            c_flag;
    logic            z_flag;
    logic            halted;
    logic            illegal_op;

    modport master (
        input  inst_data, alu_cout, alu_zout,
        output pc, alu_sel, load_shift, a_src, reg_addr,
               acc_we, reg_we, c_flag, z_flag, halted, illegal_op
    );

    modport slave (
        output inst_data, alu_cout, alu_zout,
        input  pc, alu_sel, load_shift, a_src, reg_addr,
               acc_we, reg_we, c_flag, z_flag, halted, illegal_op
    );
endinterface

// File: rtl/alu_control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit micro.
// All ALU controls and strobes are registered and only non-idle in EXEC.
module alu_control_unit #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_control_unit_if.master  bus
);
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_OPERAND, S_EXEC, S_HALT
    } state_t;

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_NOR = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_JC  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      ir_q, ir_d;
    logic [7:0]      tgt_q, tgt_d;
    logic            c_q, c_d, z_q, z_d;
    logic [1:0]      alu_sel_q, alu_sel_d;
    logic [1:0]      load_shift_q, load_shift_d;
    logic            a_src_q, a_src_d;
    logic [3:0]      reg_addr_q, reg_addr_d;
    logic            acc_we_q, acc_we_d;
    logic            reg_we_q, reg_we_d;
    logic            halted_q, halted_d;
    logic            illegal_q, illegal_d;
    logic [3:0]      op;

    assign op = ir_q[7:4];

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        tgt_d        = tgt_q;
        c_d          = c_q;
        z_d          = z_q;
        reg_addr_d   = reg_addr_q;
        halted_d     = halted_q;
        alu_sel_d    = 2'b00;
        load_shift_d = 2'b00;
        a_src_d      = 1'b0;
        acc_we_d     = 1'b0;
        reg_we_d     = 1'b0;
        illegal_d    = 1'b0;

        case (state_q)
            S_FETCH: begin
                ir_d    = bus.inst_data;
                pc_d    = pc_q + PC_ONE;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                reg_addr_d = ir_q[3:0];
                state_d    = S_EXEC;
                // Controls are loaded here so they are flop outputs during EXEC.
                case (op)
                    OP_LDA: begin a_src_d = 1'b1; load_shift_d = 2'b10; acc_we_d = 1'b1; end
                    OP_STA: reg_we_d = 1'b1;
                    OP_ADD: begin alu_sel_d = 2'b10; acc_we_d = 1'b1; end
                    OP_SUB: begin alu_sel_d = 2'b11; acc_we_d = 1'b1; end
                    OP_NOR: begin alu_sel_d = 2'b01; acc_we_d = 1'b1; end
                    OP_SHL: begin load_shift_d = 2'b01; acc_we_d = 1'b1; end
                    OP_SHR: begin load_shift_d = 2'b11; acc_we_d = 1'b1; end
                    OP_JMP, OP_JZ, OP_JC: state_d = S_OPERAND;
                    4'hB, 4'hC, 4'hD, 4'hE: illegal_d = 1'b1;
                    default: ;
                endcase
            end
            S_OPERAND: begin
                tgt_d   = bus.inst_data;
                pc_d    = pc_q + PC_ONE;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (op)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        c_d = bus.alu_cout;
                        z_d = bus.alu_zout;
                    end
                    OP_NOR, OP_SHL, OP_SHR: begin
                        c_d = 1'b0;
                        z_d = bus.alu_zout;
                    end
                    OP_JMP: pc_d = PC_W'(tgt_q);
                    OP_JZ:  if (z_q) pc_d = PC_W'(tgt_q);
                    OP_JC:  if (c_q) pc_d = PC_W'(tgt_q);
                    OP_HLT: begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            ir_q         <= 8'h00;
            tgt_q        <= 8'h00;
            c_q          <= 1'b0;
            z_q          <= 1'b0;
            alu_sel_q    <= 2'b00;
            load_shift_q <= 2'b00;
            a_src_q      <= 1'b0;
            reg_addr_q   <= 4'h0;
            acc_we_q     <= 1'b0;
            reg_we_q     <= 1'b0;
            halted_q     <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            tgt_q        <= tgt_d;
            c_q          <= c_d;
            z_q          <= z_d;
            alu_sel_q    <= alu_sel_d;
            load_shift_q <= load_shift_d;
            a_src_q      <= a_src_d;
            reg_addr_q   <= reg_addr_d;
            acc_we_q     <= acc_we_d;
            reg_we_q     <= reg_we_d;
            halted_q     <= halted_d;
            illegal_q    <= illegal_d;
        end
    end

    assign bus.pc         = pc_q;
    assign bus.alu_sel    = alu_sel_q;
    assign bus.load_shift = load_shift_q;
    assign bus.a_src      = a_src_q;
    assign bus.reg_addr   = reg_addr_q;
    assign bus.acc_we     = acc_we_q;
    assign bus.reg_we     = reg_we_q;
    assign bus.c_flag     = c_q;
    assign bus.z_flag     = z_q;
    assign bus.halted     = halted_q;
    assign bus.illegal_op = illegal_q;
endmodule

// File: tb/tb_alu_control_unit.sv
// Bench for alu_control_unit: ROM + accumulator datapath around the DUT,
// checked against an instruction-level model of the micro.
module tb_alu_control_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic preload = 1'b0;

    alu_control_unit_if #(.PC_W(8)) bus ();
    alu_control_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    logic [7:0] rom [256];
    logic [7:0] init_regs [16];
    logic [7:0] init_acc;
    logic [7:0] dp_regs [16];
    logic [7:0] dp_acc;
    logic [7:0] alu_a, alu_b, alu_res;
    logic       alu_c;

    assign bus.inst_data = rom[bus.pc];

    // Datapath ALU; shift carries are deliberately non-zero so the sequencer must clear C.
    always_comb begin
        alu_a   = bus.a_src ? dp_regs[bus.reg_addr] : dp_acc;
        alu_b   = dp_regs[bus.reg_addr];
        alu_res = 8'h00;
        alu_c   = 1'b0;
        case (bus.alu_sel)
            2'b10: {alu_c, alu_res} = {1'b0, alu_a} + {1'b0, alu_b};
            2'b11: {alu_c, alu_res} = {1'b0, alu_a} - {1'b0, alu_b};
            2'b01: alu_res = ~(alu_a | alu_b);
            default: case (bus.load_shift)
                2'b10: alu_res = alu_a;
                2'b01: {alu_c, alu_res} = {alu_a, 1'b0};
                2'b11: begin alu_res = alu_a >> 1; alu_c = alu_a[0]; end
                default: alu_res = 8'h00;
            endcase
        endcase
    end
    assign bus.alu_cout = alu_c;
    assign bus.alu_zout = (alu_res == 8'h00);

    always @(posedge clk) begin
        if (!rst_n) begin
            if (preload) begin
                dp_acc <= init_acc;
                for (int i = 0; i < 16; i++) dp_regs[i] <= init_regs[i];
            end
        end else begin
            if (bus.acc_we) dp_acc <= alu_res;
            if (bus.reg_we) dp_regs[bus.reg_addr] <= dp_acc;
        end
    end

    // Instruction-level model state
    logic [7:0] m_pc, m_acc;
    logic [7:0] m_regs [16];
    logic       m_c, m_z, m_halted;
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctrl(input string tag, input logic [1:0] sel, input logic [1:0] ls,
                            input logic asrc, input logic accwe, input logic regwe, input logic ill);
        chk({tag, ".ctrl"}, {bus.alu_sel, bus.load_shift, bus.a_src, bus.acc_we, bus.reg_we, bus.illegal_op},
            {sel, ls, asrc, accwe, regwe, ill});
    endtask

    task automatic chk_arch(input string tag);
        chk({tag, ".pc"}, bus.pc, m_pc);
        chk({tag, ".flags"}, {bus.c_flag, bus.z_flag}, {m_c, m_z});
        chk({tag, ".halted"}, bus.halted, m_halted);
        chk({tag, ".acc"}, dp_acc, m_acc);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    endtask

    // Reset with datapath preload; leaves the bench at the negedge of the FETCH cycle.
    task automatic do_reset(input logic pl);
        @(negedge clk);
        rst_n = 1'b0; preload = pl;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1; preload = 1'b0;
        m_pc = 8'h00; m_c = 1'b0; m_z = 1'b0; m_halted = 1'b0;
        if (pl) begin
            m_acc = init_acc;
            for (int i = 0; i < 16; i++) m_regs[i] = init_regs[i];
        end
        chk("reset.pc", bus.pc, 8'h00);
        chk("reset.flags", {bus.c_flag, bus.z_flag, bus.halted}, 3'b000);
        chk("reset.reg_addr", bus.reg_addr, 4'h0);
        chk_ctrl("reset", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Runs one instruction from the FETCH-cycle negedge to the next FETCH-cycle negedge.
    task automatic do_instr(input string tag);
        logic [7:0] ib, tgt, p1, nxt;
        logic [3:0] opc, n;
        logic [8:0] wide;
        logic [1:0] e_sel, e_ls;
        logic       e_asrc, e_accwe, e_regwe, e_ill;
        int         lat;
        ib  = rom[m_pc];
        opc = ib[7:4];
        n   = ib[3:0];
        p1  = m_pc + 8'd1;
        tgt = rom[p1];
        lat = (opc == 4'h8 || opc == 4'h9 || opc == 4'hA) ? 4 : 3;
        e_sel = 2'b00; e_ls = 2'b00; e_asrc = 1'b0; e_accwe = 1'b0; e_regwe = 1'b0; e_ill = 1'b0;
        case (opc)
            4'h1: begin e_asrc = 1'b1; e_ls = 2'b10; e_accwe = 1'b1; end
            4'h2: e_regwe = 1'b1;
            4'h3: begin e_sel = 2'b10; e_accwe = 1'b1; end
            4'h4: begin e_sel = 2'b11; e_accwe = 1'b1; end
            4'h5: begin e_sel = 2'b01; e_accwe = 1'b1; end
            4'h6: begin e_ls = 2'b01; e_accwe = 1'b1; end
            4'h7: begin e_ls = 2'b11; e_accwe = 1'b1; end
            4'hB, 4'hC, 4'hD, 4'hE: e_ill = 1'b1;
            default: ;
        endcase
        for (int k = 0; k < lat; k++) begin
            if (k == lat - 1) chk_ctrl({tag, ".exec"}, e_sel, e_ls, e_asrc, e_accwe, e_regwe, e_ill);
            else              chk_ctrl({tag, ".pre"}, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
        end
        nxt = (lat == 4) ? m_pc + 8'd2 : p1;
        case (opc)
            4'h1: begin m_acc = m_regs[n]; m_c = 1'b0; m_z = (m_acc == 8'h00); end
            4'h2: m_regs[n] = m_acc;
            4'h3: begin wide = {1'b0, m_acc} + {1'b0, m_regs[n]}; m_acc = wide[7:0]; m_c = wide[8]; m_z = (m_acc == 8'h00); end
            4'h4: begin wide = {1'b0, m_acc} - {1'b0, m_regs[n]}; m_acc = wide[7:0]; m_c = wide[8]; m_z = (m_acc == 8'h00); end
            4'h5: begin m_acc = ~(m_acc | m_regs[n]); m_c = 1'b0; m_z = (m_acc == 8'h00); end
            4'h6: begin m_acc = m_acc << 1; m_c = 1'b0; m_z = (m_acc == 8'h00); end
            4'h7: begin m_acc = m_acc >> 1; m_c = 1'b0; m_z = (m_acc == 8'h00); end
            4'h8: nxt = tgt;
            4'h9: if (m_z) nxt = tgt;
            4'hA: if (m_c) nxt = tgt;
            4'hF: m_halted = 1'b1;
            default: ;
        endcase
        m_pc = nxt;
        chk_arch(tag);
        chk({tag, ".reg_addr"}, bus.reg_addr, n);
    endtask

    task automatic hold_halt(input string tag);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk({tag, ".hold_pc"}, bus.pc, m_pc);
            chk({tag, ".hold_halted"}, bus.halted, 1'b1);
            chk_ctrl({tag, ".hold"}, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) init_regs[i] = 8'h00;
        init_acc = 8'h00;
        clear_rom();

        // ADD overflow, then HLT holding pc=03
        init_regs[0] = 8'hF0; init_regs[1] = 8'h20;
        rom[0] = 8'h10; rom[1] = 8'h31; rom[2] = 8'hF0;
        do_reset(1'b1);
        do_instr("t2.lda");
        do_instr("t2.add");
        chk("t2.carry", bus.c_flag, 1'b1);
        do_instr("t2.hlt");
        chk("t2.halt_pc", bus.pc, 8'h03);
        hold_halt("t2");

        // SUB to zero, JZ taken to 0x20, then JZ not taken
        clear_rom();
        init_regs[0] = 8'h05; init_regs[1] = 8'h07;
        rom[0] = 8'h10; rom[1] = 8'h40; rom[2] = 8'h90; rom[3] = 8'h20;
        rom[8'h20] = 8'h11; rom[8'h21] = 8'h90; rom[8'h22] = 8'h40; rom[8'h23] = 8'hF0;
        do_reset(1'b1);
        do_instr("t3.lda");
        do_instr("t3.sub");
        chk("t3.sub_flags", {bus.c_flag, bus.z_flag}, 2'b01);
        do_instr("t3.jz_taken");
        chk("t3.jz_target", bus.pc, 8'h20);
        do_instr("t3.lda");
        do_instr("t3.jz_not");
        chk("t3.jz_fall", bus.pc, 8'h23);
        do_instr("t3.hlt");

        // JMP whose operand byte sits at FF
        clear_rom();
        rom[8'h00] = 8'h80; rom[8'h01] = 8'hFE;
        rom[8'hFE] = 8'h80; rom[8'hFF] = 8'h10; rom[8'h10] = 8'hF0;
        do_reset(1'b1);
        do_instr("t4.jmp_fe");
        do_instr("t4.jmp_wrap");
        chk("t4.target", bus.pc, 8'h10);
        do_instr("t4.hlt");

        // Illegal opcode with flags set; SHR of 01
        clear_rom();
        init_regs[0] = 8'h00; init_regs[1] = 8'h01;
        rom[0] = 8'h10; rom[1] = 8'hC3; rom[2] = 8'h11; rom[3] = 8'h70; rom[4] = 8'hF0;
        do_reset(1'b1);
        do_instr("t5.lda0");
        do_instr("t5.illegal");
        chk("t5.flags_held", {bus.c_flag, bus.z_flag}, 2'b01);
        do_instr("t6.lda1");
        do_instr("t6.shr");
        chk("t6.shr_flags", {bus.c_flag, bus.z_flag}, 2'b01);
        do_instr("t6.hlt");

        // Reset during ADD EXEC: no acc write, flags cleared
        clear_rom();
        init_regs[0] = 8'h00; init_regs[1] = 8'h05;
        rom[0] = 8'h10; rom[1] = 8'h31; rom[2] = 8'hF0;
        do_reset(1'b1);
        do_instr("t1.lda");
        @(negedge clk); @(negedge clk);
        chk("t1.in_exec", {bus.alu_sel, bus.acc_we}, 3'b101);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = 8'h00; m_c = 1'b0; m_z = 1'b0;
        chk("t1.pc", bus.pc, 8'h00);
        chk("t1.acc_we", bus.acc_we, 1'b0);
        chk("t1.flags", {bus.c_flag, bus.z_flag}, 2'b00);
        chk("t1.acc_kept", dp_acc, 8'h00);
        do_instr("t1.refetch");
        do_instr("t1.add");
        do_instr("t1.hlt");

        // Random programs without HLT
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 16; i++) init_regs[i] = 8'($urandom_range(0, 255));
            init_acc = 8'($urandom_range(0, 255));
            for (int a = 0; a < 256; a++) begin
                logic [3:0] ro;
                logic [3:0] rn;
                ro = 4'($urandom_range(0, 14));
                rn = 4'($urandom_range(0, 15));
                rom[a] = {ro, rn};
            end
            do_reset(1'b1);
            for (int s = 0; s < 50; s++) do_instr("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
